// File: rtl/fp_round_pkg.sv
// Shared types, default widths and helpers for the FP significand rounding pipe.
package fp_round_pkg;

   // Rounding mode encodings carried on i_rmode.
   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rmode_e;

   localparam int unsigned DEF_SIZE_MAN_IN  = 28;
   localparam int unsigned DEF_SIZE_MAN_OUT = 24;
   localparam int unsigned DEF_SIZE_EXP     = 8;

   // True when the low 'width' bits of exp are all ones (NaN/Inf exponent); width <= 32.
   function automatic logic is_exp_max(input logic [31:0] exp, input int unsigned width);
      logic [31:0] mask;
      mask = (32'h1 << width) - 32'h1;
      return (exp & mask) == mask;
   endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational round-up decision from LSB/guard/sticky, sign and mode.
// FP_ROUND_PIPE_RMM_EN adds round-to-nearest-ties-away on mode 100.
module fp_round_decide
   import fp_round_pkg::*;
(
   input  logic       lsb,
   input  logic       g,
   input  logic       s,
   input  logic       sign,
   input  logic [2:0] rmode,
   output logic       inc_c,
   output logic       inexact_c
);

   // Increment decision per mode; unlisted encodings round to nearest even.
   always_comb begin
      inc_c     = 1'b0;
      inexact_c = g | s;
      case (rmode)
         RM_RTZ:  inc_c = 1'b0;
         RM_RDN:  inc_c = sign & (g | s);
         RM_RUP:  inc_c = ~sign & (g | s);
`ifdef FP_ROUND_PIPE_RMM_EN
         RM_RMM:  inc_c = g;
`endif
         default: inc_c = g & (s | lsb);
      endcase
   end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 significand rounding pipe with valid/ready on both sides.
// Stage 1 registers the round decision, stage 2 the rounded/renormalised result.
// Define FP_ROUND_PIPE_RMM_EN to enable RMM on rounding mode 100.
module fp_round_pipe
   import fp_round_pkg::*;
#(
   parameter int unsigned SIZE_MAN_IN  = DEF_SIZE_MAN_IN,
   parameter int unsigned SIZE_MAN_OUT = DEF_SIZE_MAN_OUT,
   parameter int unsigned SIZE_EXP     = DEF_SIZE_EXP
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic                    i_sign,
   input  logic [SIZE_EXP-1:0]     i_exp,
   input  logic [SIZE_MAN_IN-1:0]  i_man,
   input  logic [2:0]              i_rmode,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_sign,
   output logic [SIZE_EXP-1:0]     o_exp,
   output logic [SIZE_MAN_OUT-1:0] o_man,
   output logic                    o_inexact,
   output logic                    o_overflow
);

   localparam int unsigned G_IDX = SIZE_MAN_IN - SIZE_MAN_OUT - 1;

   logic                    s1_v;
   logic                    s1_sign;
   logic [SIZE_EXP-1:0]     s1_exp;
   logic [SIZE_MAN_OUT-1:0] s1_kept;
   logic                    s1_inc;
   logic                    s1_inexact;

   logic s1_load_c;
   logic s2_load_c;

   logic [SIZE_MAN_OUT-1:0] in_kept_c;
   logic                    in_g_c;
   logic                    in_s_c;
   logic                    in_special_c;
   logic                    dec_inc_c;
   logic                    dec_inexact_c;

   logic [SIZE_MAN_OUT:0]   sum_c;
   logic [SIZE_EXP-1:0]     exp_inc_c;
   logic [SIZE_MAN_OUT-1:0] man_nx_c;
   logic [SIZE_EXP-1:0]     exp_nx_c;
   logic                    ovf_nx_c;

   // Flow control: a stage loads when it is empty or its consumer drains it.
   assign s2_load_c = ~o_valid | i_ready;
   assign s1_load_c = ~s1_v | s2_load_c;
   assign o_ready   = s1_load_c;

   // Field split of the incoming significand.
   assign in_kept_c    = i_man[SIZE_MAN_IN-1 -: SIZE_MAN_OUT];
   assign in_g_c       = i_man[G_IDX];
   assign in_s_c       = |i_man[G_IDX-1:0];
   assign in_special_c = is_exp_max(32'(i_exp), SIZE_EXP);

   fp_round_decide u_decide (
      .lsb       (in_kept_c[0]),
      .g         (in_g_c),
      .s         (in_s_c),
      .sign      (i_sign),
      .rmode     (i_rmode),
      .inc_c     (dec_inc_c),
      .inexact_c (dec_inexact_c)
   );

   // Stage 1: capture the beat and its rounding decision; NaN/Inf passes unrounded.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_v       <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_kept    <= '0;
         s1_inc     <= 1'b0;
         s1_inexact <= 1'b0;
      end else if (s1_load_c) begin
         s1_v <= i_valid;
         if (i_valid) begin
            s1_sign    <= i_sign;
            s1_exp     <= i_exp;
            s1_kept    <= in_kept_c;
            s1_inc     <= dec_inc_c & ~in_special_c;
            s1_inexact <= dec_inexact_c & ~in_special_c;
         end
      end
   end

   // Increment, renormalise on carry-out and saturate to infinity on overflow.
   always_comb begin
      sum_c     = {1'b0, s1_kept} + (SIZE_MAN_OUT+1)'(s1_inc);
      exp_inc_c = s1_exp + SIZE_EXP'(1);
      man_nx_c  = sum_c[SIZE_MAN_OUT-1:0];
      exp_nx_c  = s1_exp;
      ovf_nx_c  = 1'b0;
      if (sum_c[SIZE_MAN_OUT]) begin
         if (is_exp_max(32'(exp_inc_c), SIZE_EXP)) begin
            exp_nx_c = '1;
            man_nx_c = '0;
            ovf_nx_c = 1'b1;
         end else begin
            exp_nx_c = exp_inc_c;
            man_nx_c = {1'b1, {(SIZE_MAN_OUT-1){1'b0}}};
         end
      end
   end

   // Stage 2: result register; holds while downstream stalls.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid    <= 1'b0;
         o_sign     <= 1'b0;
         o_exp      <= '0;
         o_man      <= '0;
         o_inexact  <= 1'b0;
         o_overflow <= 1'b0;
      end else if (s2_load_c) begin
         o_valid <= s1_v;
         if (s1_v) begin
            o_sign     <= s1_sign;
            o_exp      <= exp_nx_c;
            o_man      <= man_nx_c;
            o_inexact  <= s1_inexact;
            o_overflow <= ovf_nx_c;
         end
      end
   end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed self-checking bench for fp_round_pipe at default widths.
module tb_fp_round_pipe;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        i_sign = 1'b0;
   logic [7:0]  i_exp = 8'h00;
   logic [27:0] i_man = 28'h0;
   logic [2:0]  i_rmode = 3'b000;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic        o_sign;
   logic [7:0]  o_exp;
   logic [23:0] o_man;
   logic        o_inexact;
   logic        o_overflow;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        sgn;
      logic [7:0]  e;
      logic [27:0] m;
      logic [2:0]  rm;
      logic [7:0]  xe;
      logic [23:0] xm;
      logic        xi;
      logic        xo;
   } vec_t;

   fp_round_pipe dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_sign     (i_sign),
      .i_exp      (i_exp),
      .i_man      (i_man),
      .i_rmode    (i_rmode),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_sign     (o_sign),
      .o_exp      (o_exp),
      .o_man      (o_man),
      .o_inexact  (o_inexact),
      .o_overflow (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Push one beat with no backpressure and capture its result (bounded wait).
   task automatic drive_one(input logic sgn, input logic [7:0] e, input logic [27:0] m,
                            input logic [2:0] rm, output logic rs, output logic [7:0] re,
                            output logic [23:0] rman, output logic rinx, output logic rovf,
                            output bit ok, output int lat);
      i_sign  = sgn;
      i_exp   = e;
      i_man   = m;
      i_rmode = rm;
      i_ready = 1'b1;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      ok  = 1'b0;
      lat = 0;
      for (int k = 0; k < 5; k++) begin
         if (o_valid) begin
            ok  = 1'b1;
            lat = k + 1;
            break;
         end
         step();
      end
      rs   = o_sign;
      re   = o_exp;
      rman = o_man;
      rinx = o_inexact;
      rovf = o_overflow;
      step();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", o_ready); end
      total++; if (o_man !== 24'h0) begin bad++; $display("FAIL reset_man: got %h want 000000", o_man); end
      total++; if (o_exp !== 8'h0) begin bad++; $display("FAIL reset_exp: got %h want 00", o_exp); end
      total++; if ({o_sign, o_inexact, o_overflow} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got %b want 000", {o_sign, o_inexact, o_overflow});
      end
      step();
   endtask

   task automatic test_rounding();
      vec_t tv[8];
      logic rs, ri, ro;
      logic [7:0] re;
      logic [23:0] rm;
      bit ok;
      int lat;
      tv[0] = '{1'b0, 8'h40, 28'h8000008, 3'b000, 8'h40, 24'h800000, 1'b1, 1'b0};
      tv[1] = '{1'b0, 8'h40, 28'h8000018, 3'b000, 8'h40, 24'h800002, 1'b1, 1'b0};
      tv[2] = '{1'b0, 8'h40, 28'h8000001, 3'b011, 8'h40, 24'h800001, 1'b1, 1'b0};
      tv[3] = '{1'b1, 8'h40, 28'h8000001, 3'b011, 8'h40, 24'h800000, 1'b1, 1'b0};
      tv[4] = '{1'b1, 8'h40, 28'h8000001, 3'b010, 8'h40, 24'h800001, 1'b1, 1'b0};
      tv[5] = '{1'b0, 8'h40, 28'h8000001, 3'b001, 8'h40, 24'h800000, 1'b1, 1'b0};
      tv[6] = '{1'b0, 8'h40, 28'h8000001, 3'b000, 8'h40, 24'h800000, 1'b1, 1'b0};
      tv[7] = '{1'b1, 8'h33, 28'hABCDEF0, 3'b011, 8'h33, 24'hABCDEF, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         drive_one(tv[i].sgn, tv[i].e, tv[i].m, tv[i].rm, rs, re, rm, ri, ro, ok, lat);
         total++;
         if (!ok || {rs, re, rm, ri, ro} !== {tv[i].sgn, tv[i].xe, tv[i].xm, tv[i].xi, tv[i].xo}) begin
            bad++;
            $display("FAIL rounding[%0d]: got valid=%b s=%b exp=%h man=%h inx=%b ovf=%b want s=%b exp=%h man=%h inx=%b ovf=%b",
                     i, ok, rs, re, rm, ri, ro, tv[i].sgn, tv[i].xe, tv[i].xm, tv[i].xi, tv[i].xo);
         end
         if (i == 0) begin
            total++;
            if (lat !== 2) begin bad++; $display("FAIL latency: got %0d want 2", lat); end
         end
      end
   endtask

   task automatic test_carry_overflow();
      vec_t tv[4];
      logic rs, ri, ro;
      logic [7:0] re;
      logic [23:0] rm;
      bit ok;
      int lat;
      tv[0] = '{1'b0, 8'h10, 28'hFFFFFF8, 3'b000, 8'h11, 24'h800000, 1'b1, 1'b0};
      tv[1] = '{1'b0, 8'hFE, 28'hFFFFFF8, 3'b000, 8'hFF, 24'h000000, 1'b1, 1'b1};
      tv[2] = '{1'b0, 8'hFE, 28'hFFFFFF8, 3'b001, 8'hFE, 24'hFFFFFF, 1'b1, 1'b0};
      tv[3] = '{1'b1, 8'hFE, 28'hFFFFFF1, 3'b010, 8'hFF, 24'h000000, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive_one(tv[i].sgn, tv[i].e, tv[i].m, tv[i].rm, rs, re, rm, ri, ro, ok, lat);
         total++;
         if (!ok || {rs, re, rm, ri, ro} !== {tv[i].sgn, tv[i].xe, tv[i].xm, tv[i].xi, tv[i].xo}) begin
            bad++;
            $display("FAIL carry_ovf[%0d]: got valid=%b s=%b exp=%h man=%h inx=%b ovf=%b want s=%b exp=%h man=%h inx=%b ovf=%b",
                     i, ok, rs, re, rm, ri, ro, tv[i].sgn, tv[i].xe, tv[i].xm, tv[i].xi, tv[i].xo);
         end
      end
   endtask

   task automatic test_special();
      vec_t tv[3];
      logic rs, ri, ro;
      logic [7:0] re;
      logic [23:0] rm;
      bit ok;
      int lat;
      // NaN/Inf exponent passes through unrounded with clear flags.
      tv[0] = '{1'b0, 8'hFF, 28'hFFFFFF8, 3'b011, 8'hFF, 24'hFFFFFF, 1'b0, 1'b0};
`ifdef FP_ROUND_PIPE_RMM_EN
      tv[1] = '{1'b0, 8'h40, 28'h8000008, 3'b100, 8'h40, 24'h800001, 1'b1, 1'b0};
`else
      tv[1] = '{1'b0, 8'h40, 28'h8000008, 3'b100, 8'h40, 24'h800000, 1'b1, 1'b0};
`endif
      tv[2] = '{1'b0, 8'h40, 28'h8000008, 3'b111, 8'h40, 24'h800000, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive_one(tv[i].sgn, tv[i].e, tv[i].m, tv[i].rm, rs, re, rm, ri, ro, ok, lat);
         total++;
         if (!ok || {rs, re, rm, ri, ro} !== {tv[i].sgn, tv[i].xe, tv[i].xm, tv[i].xi, tv[i].xo}) begin
            bad++;
            $display("FAIL special[%0d]: got valid=%b s=%b exp=%h man=%h inx=%b ovf=%b want s=%b exp=%h man=%h inx=%b ovf=%b",
                     i, ok, rs, re, rm, ri, ro, tv[i].sgn, tv[i].xe, tv[i].xm, tv[i].xi, tv[i].xo);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] got[$];
      logic [34:0] held = '0;
      bit held_set = 1'b0;
      int unstable = 0;
      int idx = 0;
      int acc_stall = 0;
      bit accepted;
      for (int cyc = 0; cyc < 16; cyc++) begin
         i_ready = (cyc >= 4);
         i_valid = (idx < 4);
         i_sign  = 1'b0;
         i_exp   = 8'h20;
         i_man   = {24'h800001 + 24'(idx), 4'h0};
         i_rmode = 3'b001;
         #1;
         if (cyc == 2 || cyc == 3) begin
            total++;
            if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", cyc, o_ready); end
         end
         if (cyc < 4 && o_valid) begin
            if (!held_set) begin
               held = {o_sign, o_exp, o_man, o_inexact, o_overflow};
               held_set = 1'b1;
            end else if ({o_sign, o_exp, o_man, o_inexact, o_overflow} !== held) begin
               unstable++;
            end
         end
         if (o_valid && i_ready) got.push_back(o_man);
         accepted = i_valid && o_ready;
         step();
         if (accepted) idx++;
         if (cyc == 3) acc_stall = idx;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      total++; if (acc_stall !== 2) begin bad++; $display("FAIL stall_accept: got %0d want 2", acc_stall); end
      total++; if (!held_set || unstable !== 0) begin
         bad++; $display("FAIL stall_stable: got held=%b changes=%0d want held=1 changes=0", held_set, unstable);
      end
      total++; if (got.size() !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", got.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) begin
            total++;
            if (got[i] !== 24'h800001 + 24'(i)) begin
               bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], 24'h800001 + 24'(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      i_ready = 1'b1;
      i_sign  = 1'b0;
      i_exp   = 8'h55;
      i_rmode = 3'b001;
      i_valid = 1'b1;
      i_man   = 28'hC000000;
      step();
      i_man   = 28'hD000000;
      step();
      i_valid = 1'b0;
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", o_valid); end
      i_rst = 1'b1;
      step();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready: got %b want 1", o_ready); end
      total++; if (o_man !== 24'h0) begin bad++; $display("FAIL mid_reset_man: got %h want 000000", o_man); end
      i_rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (o_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL stale_beat: got %0d valid cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_carry_overflow();
      test_special();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
